// File: rtl/moesif_snoop_responder_pkg.sv
// Shared types for the MOESIF snoop responder: line states, bus commands,
// FSM state encodings and the combinational snoop decode.
package moesif_snoop_responder_pkg;

  // INVALID is encoded as zero so an idle/reset cacheNewState reads as "no line".
  typedef enum logic [2:0] {
    INVALID   = 3'd0,
    MODIFIED  = 3'd1,
    OWNED     = 3'd2,
    EXCLUSIVE = 3'd3,
    SHARED    = 3'd4,
    FORWARD   = 3'd5
  } CacheLineState;

  typedef enum logic [1:0] {
    BUS_READ           = 2'd0,
    BUS_READ_EXCLUSIVE = 2'd1,
    BUS_INVALIDATE     = 2'd2
  } BusCommand;

  typedef struct packed {
    logic          supply;
    CacheLineState next_state;
  } SnoopDecode;

  // Responder FSM encodings
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ARBITRATE = 3'd1;
  localparam logic [2:0] LOOKUP    = 3'd2;
  localparam logic [2:0] SUPPLY    = 3'd3;
  localparam logic [2:0] UPDATE    = 3'd4;
  localparam logic [2:0] ACK       = 3'd5;

  // True for the five states that hold a usable copy of the line.
  function automatic logic is_valid_state(input CacheLineState state);
    case (state)
      MODIFIED, OWNED, EXCLUSIVE, SHARED, FORWARD: is_valid_state = 1'b1;
      default:                                     is_valid_state = 1'b0;
    endcase
  endfunction

  // Supply decision and next line state for a snooped command hitting a valid line.
  // Only dirty/forwarding copies answer with data, and never for a pure invalidate.
  function automatic SnoopDecode snoop_decode(input CacheLineState state,
                                              input BusCommand     cmd);
    SnoopDecode d;
    d.supply     = 1'b0;
    d.next_state = INVALID;
    if (cmd == BUS_READ || cmd == BUS_READ_EXCLUSIVE) begin
      case (state)
        MODIFIED, OWNED, FORWARD: d.supply = 1'b1;
        default:                  d.supply = 1'b0;
      endcase
    end
    if (cmd == BUS_READ) begin
      case (state)
        MODIFIED, OWNED:           d.next_state = OWNED;
        EXCLUSIVE, FORWARD, SHARED: d.next_state = SHARED;
        default:                   d.next_state = INVALID;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/moesif_snoop_responder.sv
// MOESIF snoop responder: arbitrates for the cache snoop port, looks up the
// snooped line, streams the line out when this cache owns it, then writes
// the new coherence state and acknowledges the snoop.
module moesif_snoop_responder
  import moesif_snoop_responder_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int OFFSET_WIDTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     snoopRequest,
  input  BusCommand                snoopCommand,
  input  logic [ADDRESS_WIDTH-1:0] snoopAddress,
  output logic                     snoopAck,
  output logic                     sharedOut,
  output logic                     ownedOut,
  output logic [DATA_WIDTH-1:0]    dataOut,
  output logic                     dataValid,
  input  logic                     dataReady,
  output logic                     arbiterRequest,
  input  logic                     arbiterGrant,
  output logic [ADDRESS_WIDTH-1:0] cacheAddress,
  input  logic                     cacheHit,
  input  CacheLineState            cacheState,
  input  logic [DATA_WIDTH-1:0]    cacheData,
  output logic                     cacheStateWrite,
  output CacheLineState            cacheNewState
);

  localparam int TAG_W = ADDRESS_WIDTH - OFFSET_WIDTH;

  logic [2:0]              state;
  BusCommand               cmd_q;
  logic [TAG_W-1:0]        line_q;
  logic [OFFSET_WIDTH-1:0] word_q;
  logic                    hit_q;
  logic                    supply_q;
  CacheLineState           next_q;

  SnoopDecode              dec;
  logic                    lookup_valid;
  logic                    unused_offset;

  // The word offset of the snooped address never matters: the whole line is addressed.
  assign unused_offset = ^snoopAddress[OFFSET_WIDTH-1:0];

  assign dec          = snoop_decode(cacheState, cmd_q);
  assign lookup_valid = cacheHit && is_valid_state(cacheState);

  // Control FSM plus the snoop context latched on entry; reset clears everything,
  // so a snoop interrupted mid-supply leaves no trace.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cmd_q    <= BUS_READ;
      line_q   <= '0;
      word_q   <= '0;
      hit_q    <= 1'b0;
      supply_q <= 1'b0;
      next_q   <= INVALID;
    end else begin
      case (state)
        IDLE: begin
          if (snoopRequest) begin
            cmd_q  <= snoopCommand;
            line_q <= snoopAddress[ADDRESS_WIDTH-1:OFFSET_WIDTH];
            word_q <= '0;
            state  <= ARBITRATE;
          end
        end
        ARBITRATE: begin
          if (arbiterGrant) state <= LOOKUP;
        end
        LOOKUP: begin
          if (lookup_valid) begin
            hit_q    <= 1'b1;
            supply_q <= dec.supply;
            next_q   <= dec.next_state;
            state    <= dec.supply ? SUPPLY : UPDATE;
          end else begin
            hit_q    <= 1'b0;
            supply_q <= 1'b0;
            next_q   <= INVALID;
            state    <= ACK;
          end
        end
        SUPPLY: begin
          // Counter wraps to zero on the last handshake, so UPDATE sees word 0.
          if (dataReady) begin
            word_q <= word_q + 1'b1;
            if (word_q == '1) state <= UPDATE;
          end
        end
        UPDATE:  state <= ACK;
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state so reset zeroes them immediately.
  always_comb begin
    arbiterRequest  = (state != IDLE);
    dataValid       = (state == SUPPLY);
    dataOut         = dataValid ? cacheData : '0;
    cacheAddress    = {line_q, word_q};
    cacheStateWrite = (state == UPDATE);
    cacheNewState   = cacheStateWrite ? next_q : INVALID;
    snoopAck        = (state == ACK);
    sharedOut       = snoopAck && hit_q && (next_q != INVALID);
    ownedOut        = snoopAck && supply_q;
  end

endmodule

// File: doc/moesif_snoop_responder.md
MOESIF_SNOOP_RESPONDER -- requirements
Module: moesif_snoop_responder

Interface
REQ-001 Parameter ADDRESS_WIDTH SHALL default 32: bus/cache address width.
REQ-002 Parameter DATA_WIDTH SHALL default 32: data word width.
REQ-003 Parameter OFFSET_WIDTH SHALL default 4: word offset bits; a line holds 2^OFFSET_WIDTH words.
REQ-004 clock  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 snoopRequest  input  1  remote cache's bus transaction pending; held until snoopAck.
REQ-007 snoopCommand  input  BusCommand  BUS_READ, BUS_READ_EXCLUSIVE or BUS_INVALIDATE.
REQ-008 snoopAddress  input  ADDRESS_WIDTH  snooped address; offset field ignored.
REQ-009 snoopAck  output  1  one-cycle pulse: snoop complete.
REQ-010 sharedOut  output  1  valid with snoopAck: line still valid here.
REQ-011 ownedOut  output  1  valid with snoopAck: this cache supplied the line.
REQ-012 dataOut  output  DATA_WIDTH  supplied word.
REQ-013 dataValid  output  1  dataOut valid.
REQ-014 dataReady  input  1  requester accepts word.
REQ-015 arbiterRequest  output  1  request for snoop port of the cache.
REQ-016 arbiterGrant  input  1  snoop port granted.
REQ-017 cacheAddress  output  ADDRESS_WIDTH  {latched tag/index, word counter}.
REQ-018 cacheHit  input  1  combinational lookup hit for cacheAddress.
REQ-019 cacheState  input  CacheLineState  combinational state of hit line.
REQ-020 cacheData  input  DATA_WIDTH  combinational word at cacheAddress.
REQ-021 cacheStateWrite  output  1  write cacheNewState to hit line this cycle.
REQ-022 cacheNewState  output  CacheLineState  state to write.

Function
REQ-023 FSM states SHALL be IDLE, ARBITRATE, LOOKUP, SUPPLY, UPDATE, ACK.
REQ-024 IDLE: snoopRequest=1 latches command and address (offset zeroed), -> ARBITRATE next cycle.
REQ-025 ARBITRATE: arbiterRequest=1; arbiterGrant=1 -> LOOKUP; arbiterRequest held through ACK, low in IDLE.
REQ-026 LOOKUP (one cycle): miss or INVALID -> ACK with sharedOut=0, ownedOut=0, no state write.
REQ-027 LOOKUP hit: supply flag = state in {MODIFIED, OWNED, FORWARD} and command != BUS_INVALIDATE; supply -> SUPPLY, else -> UPDATE.
REQ-028 Next state on BUS_READ: MODIFIED->OWNED, OWNED->OWNED, EXCLUSIVE->SHARED, FORWARD->SHARED, SHARED->SHARED.
REQ-029 Next state on BUS_READ_EXCLUSIVE or BUS_INVALIDATE: any valid state -> INVALID.
REQ-030 SUPPLY: dataValid=1, dataOut=cacheData; word counter starts 0, increments only when dataReady=1; dataReady=0 stalls with dataOut stable.
REQ-031 SUPPLY exits to UPDATE on the handshake of word 2^OFFSET_WIDTH-1; counter wraps to 0, no extra word.
REQ-032 UPDATE (one cycle): cacheStateWrite=1, cacheNewState per REQ-028/029; -> ACK.
REQ-033 ACK (one cycle): snoopAck=1; sharedOut=1 iff hit and new state valid; ownedOut=1 iff supply flag; -> IDLE.
REQ-034 snoopRequest changes outside IDLE SHALL be ignored; a request still high in IDLE after ACK starts a new snoop.

Reset
REQ-035 reset SHALL force IDLE, counter 0 and all outputs 0 immediately, including mid-SUPPLY; no state write issued.
REQ-036 First snoop after reset release SHALL behave as from power-up.

Structure
REQ-037 CacheLineState (MODIFIED, OWNED, EXCLUSIVE, SHARED, INVALID, FORWARD) and BusCommand SHALL live in shared package types.
REQ-038 Next-state/supply decode SHALL be one combinational function in types; no sub-module.

Verification
REQ-039 Line MODIFIED, BUS_READ, OFFSET_WIDTH=4 -> 16 words in order, state OWNED, snoopAck with sharedOut=1, ownedOut=1.
REQ-040 Line EXCLUSIVE, BUS_READ -> no dataValid, state SHARED, sharedOut=1, ownedOut=0.
REQ-041 Line FORWARD, BUS_READ_EXCLUSIVE, dataReady low 3 cycles at word 5 -> word 5 held, 16 words total, state INVALID, sharedOut=0, ownedOut=1.
REQ-042 Miss, BUS_INVALIDATE -> no cacheStateWrite, snoopAck with sharedOut=0, ownedOut=0.
REQ-043 arbiterGrant withheld 10 cycles -> stays in ARBITRATE, arbiterRequest=1, no cache access.
REQ-044 reset asserted at word 7 of a supply -> all outputs 0 at once, no state write; next BUS_READ on the line completes normally.
